// File: rtl/joint_step_planner_if.sv
// Handshake and motion bus between a joint-target source and joint_step_planner.
// The master side supplies targets and halt; the planner reports status, step/dir and position.
interface joint_step_planner_if;
  logic               angle_valid;
  logic signed [12:0] th1;
  logic signed [12:0] th2;
  logic               halt;
  logic               ready;
  logic               busy;
  logic               done;
  logic               step1;
  logic               step2;
  logic               dir1;
  logic               dir2;
  logic signed [12:0] pos1;
  logic signed [12:0] pos2;

  modport master (
    output angle_valid, th1, th2, halt,
    input  ready, busy, done, step1, step2, dir1, dir2, pos1, pos2
  );

  modport slave (
    input  angle_valid, th1, th2, halt,
    output ready, busy, done, step1, step2, dir1, dir2, pos1, pos2
  );
endinterface

// File: rtl/joint_step_planner.sv
// Two-joint stepper move planner: latches joint targets, then issues synchronous step
// pulses toward them with a direction setup time, tracking signed positions in microsteps.
module joint_step_planner #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned DIR_SETUP   = 2
) (
  input  logic                clk,
  input  logic                reset,
  joint_step_planner_if.slave bus
);

  localparam int unsigned MAXC = (HALF_PERIOD > DIR_SETUP) ? HALF_PERIOD : DIR_SETUP;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    STEP_HI,
    STEP_LO,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [12:0]   tgt1_q, tgt1_d, tgt2_q, tgt2_d;
  logic [12:0]   pos1_q, pos1_d, pos2_q, pos2_d;
  logic [12:0]   rem1_q, rem1_d, rem2_q, rem2_d;
  logic          dir1_q, dir1_d, dir2_q, dir2_d;
  logic          step1_q, step1_d, step2_q, step2_d;
  logic          done_q, done_d;
  logic          halt_q, halt_d;

  logic [13:0]   d1, d2;
  logic [13:0]   a1, a2;
  logic          hi_last, lo_last, setup_last, enter_hi, stop_req;

  // 14-bit differences cannot overflow for any pair of 13-bit signed operands
  always_comb begin
    d1 = {tgt1_q[12], tgt1_q} - {pos1_q[12], pos1_q};
    d2 = {tgt2_q[12], tgt2_q} - {pos2_q[12], pos2_q};
    a1 = d1[13] ? (~d1 + 14'd1) : d1;
    a2 = d2[13] ? (~d2 + 14'd1) : d2;
  end

  always_comb begin
    setup_last = (cnt_q == CW'(DIR_SETUP - 1));
    hi_last    = (cnt_q == CW'(HALF_PERIOD - 1));
    lo_last    = hi_last;
    stop_req   = halt_q || bus.halt;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.angle_valid) state_d = LOAD;
      end
      LOAD: begin
        if (bus.halt)                      state_d = IDLE;
        else if (a1 == '0 && a2 == '0)     state_d = DONE;
        else                               state_d = SETUP;
      end
      SETUP: begin
        if (bus.halt)        state_d = IDLE;
        else if (setup_last) state_d = STEP_HI;
      end
      STEP_HI: begin
        if (hi_last) state_d = STEP_LO;
      end
      STEP_LO: begin
        if (lo_last) begin
          if (stop_req)                          state_d = IDLE;
          else if (rem1_q != '0 || rem2_q != '0) state_d = STEP_HI;
          else                                   state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enter_hi = (state_d == STEP_HI) && (state_q != STEP_HI);
    cnt_d    = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    tgt1_d  = tgt1_q;
    tgt2_d  = tgt2_q;
    pos1_d  = pos1_q;
    pos2_d  = pos2_q;
    rem1_d  = rem1_q;
    rem2_d  = rem2_q;
    dir1_d  = dir1_q;
    dir2_d  = dir2_q;
    step1_d = step1_q;
    step2_d = step2_q;
    halt_d  = halt_q;
    done_d  = (state_q == DONE);

    if (state_q == IDLE && bus.angle_valid) begin
      tgt1_d = bus.th1;
      tgt2_d = bus.th2;
    end

    // A joint with zero distance keeps its previous direction
    if (state_q == LOAD) begin
      rem1_d = a1[12:0];
      rem2_d = a2[12:0];
      if (a1 != '0) dir1_d = ~d1[13];
      if (a2 != '0) dir2_d = ~d2[13];
    end

    if (enter_hi) begin
      step1_d = (rem1_q != '0);
      step2_d = (rem2_q != '0);
      if (rem1_q != '0) begin
        rem1_d = rem1_q - 13'd1;
        pos1_d = dir1_q ? pos1_q + 13'd1 : pos1_q - 13'd1;
      end
      if (rem2_q != '0) begin
        rem2_d = rem2_q - 13'd1;
        pos2_d = dir2_q ? pos2_q + 13'd1 : pos2_q - 13'd1;
      end
    end else if (state_d != STEP_HI) begin
      step1_d = 1'b0;
      step2_d = 1'b0;
    end

    // A halt seen in either step phase stops the move after the current low phase
    if (state_q == IDLE) begin
      halt_d = 1'b0;
    end else if ((state_q == STEP_HI || state_q == STEP_LO) && bus.halt) begin
      halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt1_q  <= '0;
      tgt2_q  <= '0;
      pos1_q  <= '0;
      pos2_q  <= '0;
      rem1_q  <= '0;
      rem2_q  <= '0;
      dir1_q  <= 1'b0;
      dir2_q  <= 1'b0;
      step1_q <= 1'b0;
      step2_q <= 1'b0;
      done_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt1_q  <= tgt1_d;
      tgt2_q  <= tgt2_d;
      pos1_q  <= pos1_d;
      pos2_q  <= pos2_d;
      rem1_q  <= rem1_d;
      rem2_q  <= rem2_d;
      dir1_q  <= dir1_d;
      dir2_q  <= dir2_d;
      step1_q <= step1_d;
      step2_q <= step2_d;
      done_q  <= done_d;
      halt_q  <= halt_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.step1 = step1_q;
  assign bus.step2 = step2_q;
  assign bus.dir1  = dir1_q;
  assign bus.dir2  = dir2_q;
  assign bus.pos1  = pos1_q;
  assign bus.pos2  = pos2_q;

endmodule
